// File: rtl/row_rmw_scheduler_if.sv
// Requester, RAM read-port and RAM write-port signals of the row RMW scheduler.
// The scheduler takes the slave view; requesters and the RAM together form the master view.
interface row_rmw_scheduler_if #(
    parameter int NREQ = 4
);
    logic                 EnableChange;
    logic [NREQ-1:0]      req;
    logic [NREQ*11-1:0]   req_addr;
    logic [NREQ*48-1:0]   req_element;
    logic [NREQ*3-1:0]    req_slot;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [10:0]          ReadAddress1;
    logic [255:0]         ReadBus1;
    logic                 WE;
    logic [10:0]          WriteReq;
    logic [255:0]         WriteBus;

    modport master (
        output EnableChange, req, req_addr, req_element, req_slot, ReadBus1,
        input  ack, err, busy, ReadAddress1, WE, WriteReq, WriteBus
    );

    modport slave (
        input  EnableChange, req, req_addr, req_element, req_slot, ReadBus1,
        output ack, err, busy, ReadAddress1, WE, WriteReq, WriteBus
    );
endinterface

// File: rtl/row_rmw_scheduler.sv
// Round-robin arbiter that serialises 48-bit slot updates into 256-bit RAM rows
// as read / merge / write-back sequences, one at a time.
//
// state | meaning
// IDLE  | waiting for EnableChange and a request; grants the round-robin winner
// RD    | row read in flight; merges the element on the last read-latency edge
// WR    | write-back (or error) cycle; ack/WE high, pointer advances
module row_rmw_scheduler #(
    parameter int NREQ     = 4,
    parameter int READ_LAT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    row_rmw_scheduler_if.slave     bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t             state, stateNxt;
    logic [IDX_W-1:0]   rrPtr, rrPtrNxt;
    logic [IDX_W-1:0]   winner, winnerNxt;
    logic [CNT_W-1:0]   cnt, cntNxt;
    logic [47:0]        elemQ, elemNxt;
    logic [2:0]         slotQ, slotNxt;
    logic [NREQ-1:0]    ackQ, ackNxt;
    logic               errQ, errNxt;
    logic               busyQ, busyNxt;
    logic               weQ, weNxt;
    logic [10:0]        readAddr, readAddrNxt;
    logic [10:0]        writeAddr, writeAddrNxt;
    logic [255:0]       writeData, writeDataNxt;

    logic               grantFound;
    logic [IDX_W-1:0]   grantIdx;
    logic [255:0]       merged;

    // First requester at or after rrPtr, wrapping.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grantFound && bus.req[(int'(rrPtr) + k) % NREQ]) begin
                grantFound = 1'b1;
                grantIdx   = IDX_W'((int'(rrPtr) + k) % NREQ);
            end
        end
    end

    // Slots 5..7 do not exist; the top 16 bits of a row are never touched.
    always_comb begin
        merged = bus.ReadBus1;
        for (int s = 0; s < 5; s++) begin
            if (slotQ == 3'(s)) merged[s*48 +: 48] = elemQ;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt     = state;
        rrPtrNxt     = rrPtr;
        winnerNxt    = winner;
        cntNxt       = cnt;
        elemNxt      = elemQ;
        slotNxt      = slotQ;
        ackNxt       = ackQ;
        errNxt       = errQ;
        busyNxt      = busyQ;
        weNxt        = weQ;
        readAddrNxt  = readAddr;
        writeAddrNxt = writeAddr;
        writeDataNxt = writeData;
        case (state)
            IDLE: begin
                if (bus.EnableChange && grantFound) begin
                    winnerNxt   = grantIdx;
                    readAddrNxt = bus.req_addr[int'(grantIdx)*11 +: 11];
                    elemNxt     = bus.req_element[int'(grantIdx)*48 +: 48];
                    slotNxt     = bus.req_slot[int'(grantIdx)*3 +: 3];
                    cntNxt      = '0;
                    busyNxt     = 1'b1;
                    stateNxt    = RD;
                end
            end
            RD: begin
                cntNxt = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    stateNxt       = WR;
                    ackNxt         = '0;
                    ackNxt[winner] = 1'b1;
                    if (slotQ <= 3'd4) begin
                        weNxt        = 1'b1;
                        writeAddrNxt = readAddr;
                        writeDataNxt = merged;
                    end else begin
                        errNxt = 1'b1;
                    end
                end
            end
            WR: begin
                weNxt    = 1'b0;
                ackNxt   = '0;
                errNxt   = 1'b0;
                busyNxt  = 1'b0;
                rrPtrNxt = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
                stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rrPtr     <= '0;
            winner    <= '0;
            cnt       <= '0;
            elemQ     <= '0;
            slotQ     <= '0;
            ackQ      <= '0;
            errQ      <= 1'b0;
            busyQ     <= 1'b0;
            weQ       <= 1'b0;
            readAddr  <= '0;
            writeAddr <= '0;
            writeData <= '0;
        end else begin
            rrPtr     <= rrPtrNxt;
            winner    <= winnerNxt;
            cnt       <= cntNxt;
            elemQ     <= elemNxt;
            slotQ     <= slotNxt;
            ackQ      <= ackNxt;
            errQ      <= errNxt;
            busyQ     <= busyNxt;
            weQ       <= weNxt;
            readAddr  <= readAddrNxt;
            writeAddr <= writeAddrNxt;
            writeData <= writeDataNxt;
        end
    end

    assign bus.ack          = ackQ;
    assign bus.err          = errQ;
    assign bus.busy         = busyQ;
    assign bus.WE           = weQ;
    assign bus.ReadAddress1 = readAddr;
    assign bus.WriteReq     = writeAddr;
    assign bus.WriteBus     = writeData;
endmodule

// File: tb/tb_row_rmw_scheduler.sv
// Directed bench for row_rmw_scheduler: per-cycle vector tables for arbitration,
// hand-written sequences for merge, illegal slot, gating/abort and same-row chaining.
module tb_row_rmw_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b0;
    initial forever #5 clock = ~clock;

    row_rmw_scheduler_if #(.NREQ(4)) bus();

    row_rmw_scheduler #(.NREQ(4), .READ_LAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic         useRam  = 1'b0;
    logic         ramLoad = 1'b0;
    logic [255:0] ramInit = '0;
    logic [255:0] rdPattern = '1;
    logic [255:0] ramRd = '0;
    logic [255:0] ram [0:2047];

    always @(posedge clock) begin
        ramRd <= ram[bus.ReadAddress1];
        if (ramLoad) ram[11'h7FF] <= ramInit;
        else if (bus.WE) ram[bus.WriteReq] <= bus.WriteBus;
    end

    assign bus.ReadBus1 = useRam ? ramRd : rdPattern;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [3:0]  expAck;
        logic        expWe;
        logic        expBusy;
        logic [10:0] expRa;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [3:0] rq, input logic [3:0] ak,
                                input logic we, input logic bz, input logic [10:0] ra);
        vec_t v;
        v.en = en; v.req = rq; v.expAck = ak; v.expWe = we; v.expBusy = bz; v.expRa = ra;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int i, input logic [10:0] a, input logic [47:0] e, input logic [2:0] s);
        bus.req_addr[i*11 +: 11]    = a;
        bus.req_element[i*48 +: 48] = e;
        bus.req_slot[i*3 +: 3]      = s;
    endtask

    task automatic doReset();
        reset = 1'b0;
        bus.req = '0;
        bus.EnableChange = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic runVecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            bus.EnableChange = vecs[i].en;
            bus.req = vecs[i].req;
            tick();
            chk($sformatf("%s[%0d].ack", tag, i), 256'(bus.ack), 256'(vecs[i].expAck));
            chk($sformatf("%s[%0d].WE", tag, i), 256'(bus.WE), 256'(vecs[i].expWe));
            chk($sformatf("%s[%0d].busy", tag, i), 256'(bus.busy), 256'(vecs[i].expBusy));
            chk($sformatf("%s[%0d].ReadAddress1", tag, i), 256'(bus.ReadAddress1), 256'(vecs[i].expRa));
            chk($sformatf("%s[%0d].ack_onehot", tag, i), 256'($countones(bus.ack) <= 1), 256'(1));
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, ".ack"}, 256'(bus.ack), '0);
        chk({tag, ".err"}, 256'(bus.err), '0);
        chk({tag, ".busy"}, 256'(bus.busy), '0);
        chk({tag, ".WE"}, 256'(bus.WE), '0);
        chk({tag, ".ReadAddress1"}, 256'(bus.ReadAddress1), '0);
        chk({tag, ".WriteReq"}, 256'(bus.WriteReq), '0);
        chk({tag, ".WriteBus"}, bus.WriteBus, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [255:0] expBus1;
        logic [255:0] expChain;
        bus.EnableChange = 1'b0;
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_element = '0;
        bus.req_slot = '0;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chkAllZero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Single request, slot 2, all-ones row
        setReq(0, 11'h005, 48'hAAAA_BBBB_CCCC, 3'd2);
        rdPattern = '1;
        bus.EnableChange = 1'b1;
        bus.req = 4'b0001;
        tick();
        chk("t1.E0.busy", 256'(bus.busy), 256'(1));
        chk("t1.E0.ReadAddress1", 256'(bus.ReadAddress1), 256'(11'h005));
        setReq(0, 11'h3FF, 48'h0, 3'd4);
        tick();
        chk("t1.E1.WE", 256'(bus.WE), 256'(0));
        chk("t1.E1.ack", 256'(bus.ack), 256'(0));
        tick();
        expBus1 = '1;
        expBus1[143:96] = 48'hAAAA_BBBB_CCCC;
        chk("t1.E2.WE", 256'(bus.WE), 256'(1));
        chk("t1.E2.WriteReq", 256'(bus.WriteReq), 256'(11'h005));
        chk("t1.E2.ack", 256'(bus.ack), 256'(4'b0001));
        chk("t1.E2.err", 256'(bus.err), 256'(0));
        chk("t1.E2.WriteBus", bus.WriteBus, expBus1);
        bus.req = 4'b0000;
        tick();
        chk("t1.E3.WE", 256'(bus.WE), 256'(0));
        chk("t1.E3.busy", 256'(bus.busy), 256'(0));
        chk("t1.E3.ack", 256'(bus.ack), 256'(0));

        // Illegal slot on requester 1
        setReq(1, 11'h0AB, 48'h1234_5678_9ABC, 3'd6);
        rdPattern = {8{32'h0F0F_0F0F}};
        bus.req = 4'b0010;
        tick();
        chk("t4.E0.ReadAddress1", 256'(bus.ReadAddress1), 256'(11'h0AB));
        tick();
        tick();
        chk("t4.E2.ack", 256'(bus.ack), 256'(4'b0010));
        chk("t4.E2.err", 256'(bus.err), 256'(1));
        chk("t4.E2.WE", 256'(bus.WE), 256'(0));
        chk("t4.E2.WriteBus", bus.WriteBus, expBus1);
        chk("t4.E2.WriteReq", 256'(bus.WriteReq), 256'(11'h005));
        bus.req = 4'b0000;
        tick();
        chk("t4.E3.err", 256'(bus.err), 256'(0));
        chk("t4.E3.busy", 256'(bus.busy), 256'(0));

        // Contention: all four held from reset
        for (int i = 0; i < 4; i++) setReq(i, 11'(11'h100 + i), 48'(i + 1), 3'(i));
        doReset();
        vecs.delete();
        for (int c = 0; c < 20; c++) begin
            int g;
            int ph;
            g  = (c / 4) % 4;
            ph = c % 4;
            vecs.push_back(mk(1'b1, 4'hF, (ph == 2) ? 4'(1 << g) : 4'h0,
                              ph == 2, ph != 3, 11'(11'h100 + g)));
        end
        runVecs("t2");

        // Pointer fairness: serve 2, then 0101 resolves as 0 then 2
        doReset();
        vecs.delete();
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 0, 1, 11'h102));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 0, 1, 11'h102));
        vecs.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 11'h102));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 11'h102));
        vecs.push_back(mk(1, 4'b0101, 4'b0000, 0, 1, 11'h100));
        vecs.push_back(mk(1, 4'b0101, 4'b0000, 0, 1, 11'h100));
        vecs.push_back(mk(1, 4'b0101, 4'b0001, 1, 1, 11'h100));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 0, 0, 11'h100));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 0, 1, 11'h102));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 0, 1, 11'h102));
        vecs.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 11'h102));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 11'h102));
        runVecs("t3");

        // Gating and abort
        doReset();
        rdPattern = '0;
        setReq(1, 11'h055, 48'h0000_0000_0001, 3'd0);
        bus.EnableChange = 1'b1;
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        chk("t5.pre.ack", 256'(bus.ack), 256'(4'b0010));
        bus.req = 4'b0000;
        tick();
        setReq(0, 11'h0C3, 48'h0000_0000_00C3, 3'd3);
        setReq(2, 11'h0E2, 48'h0000_0000_00E2, 3'd1);
        bus.EnableChange = 1'b0;
        bus.req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5.gated[%0d].busy", i), 256'(bus.busy), 256'(0));
            chk($sformatf("t5.gated[%0d].ReadAddress1", i), 256'(bus.ReadAddress1), 256'(11'h055));
        end
        bus.EnableChange = 1'b1;
        tick();
        chk("t5.E0.busy", 256'(bus.busy), 256'(1));
        chk("t5.E0.ReadAddress1", 256'(bus.ReadAddress1), 256'(11'h0C3));
        tick();
        reset = 1'b0;
        #1;
        chkAllZero("t5.abort");
        bus.req = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("t5.inreset[%0d].WE", i), 256'(bus.WE), 256'(0));
            chk($sformatf("t5.inreset[%0d].ack", i), 256'(bus.ack), 256'(0));
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("t5.regrant.ReadAddress1", 256'(bus.ReadAddress1), 256'(11'h0C3));
        tick();
        tick();
        chk("t5.regrant.ack", 256'(bus.ack), 256'(4'b0001));
        chk("t5.regrant.WriteReq", 256'(bus.WriteReq), 256'(11'h0C3));
        bus.req = 4'b0000;
        tick();

        // Same-address chain through the RAM model
        doReset();
        useRam = 1'b1;
        ramInit = {8{32'h1234_5678}};
        ramLoad = 1'b1;
        tick();
        ramLoad = 1'b0;
        setReq(0, 11'h7FF, 48'h1111_2222_3333, 3'd0);
        bus.EnableChange = 1'b1;
        bus.req = 4'b0001;
        tick();
        tick();
        tick();
        expChain = {8{32'h1234_5678}};
        expChain[47:0] = 48'h1111_2222_3333;
        chk("t6.first.WriteBus", bus.WriteBus, expChain);
        chk("t6.first.WriteReq", 256'(bus.WriteReq), 256'(11'h7FF));
        setReq(0, 11'h7FF, 48'h4444_5555_6666, 3'd1);
        tick();
        tick();
        chk("t6.second.ReadAddress1", 256'(bus.ReadAddress1), 256'(11'h7FF));
        tick();
        tick();
        expChain[95:48] = 48'h4444_5555_6666;
        chk("t6.second.WE", 256'(bus.WE), 256'(1));
        chk("t6.second.WriteBus", bus.WriteBus, expChain);
        bus.req = 4'b0000;
        tick();
        chk("t6.ram.row7FF", ram[11'h7FF], expChain);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/row_rmw_scheduler.md
Name: row_rmw_scheduler

Overview:
- Serialises element-into-row updates from NREQ requesters onto the shared 256-bit row RAM.
- Each update is a read-modify-write: read row, overwrite one 48-bit slot, write the row back.
- Sits between the update engines and the RAM read port 1 / write port.
- Grants requesters round-robin so no requester starves.

Parameters:
NREQ, 4, number of requesters
READ_LAT, 2, clock edges after the edge that drives ReadAddress1 at which ReadBus1 is sampled (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
EnableChange  input  1  new grants allowed only while high
req  input  NREQ  per-requester request level; held until its ack
req_addr  input  NREQ*11  row address, requester i at [11i+10:11i]
req_element  input  NREQ*48  element data, requester i at [48i+47:48i]
req_slot  input  NREQ*3  slot index 0..4, requester i at [3i+2:3i]
ack  output  NREQ  one-cycle one-hot completion pulse
err  output  1  one-cycle pulse with ack when slot index > 4
busy  output  1  high while not IDLE
ReadAddress1  output  11  RAM read address, registered
ReadBus1  input  256  RAM read data
WE  output  1  RAM write enable, registered
WriteReq  output  11  RAM write address
WriteBus  output  256  RAM write data

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, cnt=0.
- All outputs clear to 0 on reset: ack, err, busy, WE, ReadAddress1, WriteReq, WriteBus.
- A reset mid-operation aborts the operation, issues no write and sends no ack.
- States: IDLE, RD, WR.
- IDLE, on an edge with EnableChange=1 and |req:
  - Winner = first set req bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch winner index, addr, element and slot.
  - ReadAddress1<=addr, cnt<=0, busy<=1, state<=RD.
  - Grant decision uses only the sampled req value. Simultaneous requests are resolved by the round-robin order alone.
- RD:
  - Each edge cnt<=cnt+1. ReadAddress1 is held.
  - On the edge where cnt==READ_LAT-1, merge row = ReadBus1 with bits [48s+47:48s] replaced by the element (s=slot).
  - All other bits, including [255:240], pass through unchanged.
  - That same edge sets state<=WR and ack<=onehot(winner).
  - If s<=4: WE<=1, WriteReq<=addr, WriteBus<=merged.
  - If s>4: WE stays 0, WriteBus unchanged, err<=1.
- WR:
  - Next edge: WE<=0, ack<=0, err<=0, busy<=0, rr_ptr<=(winner+1) mod NREQ, state<=IDLE.
  - WriteReq and WriteBus hold their last value.
- Timing, with grant at edge E0:
  - WE and ack are high for exactly the cycle between E(READ_LAT) and E(READ_LAT+1).
  - The earliest next grant is at E(READ_LAT+2).
  - Throughput is one update per READ_LAT+2 cycles.
- Requester rule:
  - Deassert req during the ack cycle, or hold it to request another update (re-arbitrated normally).
  - req_addr, req_element and req_slot are sampled only at grant; later changes are ignored.
- EnableChange=0 blocks new grants only. An in-flight operation always completes.
- Back-to-back updates to the same address are coherent: operations never overlap, so each read sees the previous write.
- ack is never asserted for more than one bit.

Test Plan:
1. Reset then single request: req=0001, addr=0x005, slot=2, element=0xAAAA_BBBB_CCCC, ReadBus1=all-1s. Required: grant at E0; ReadAddress1=0x005; at E2 WE=1, WriteReq=0x005, ack=0001; WriteBus[143:96]=0xAAAABBBBCCCC, all other bits 1; at E3 WE=0, busy=0.
2. Contention: req=1111 held continuously from reset. Required: grant order 0,1,2,3,0; each ack 4 cycles apart; never two ack bits set.
3. Pointer fairness: complete requester 2, then assert req=0101. Required: requester 0 is skipped in favour of the search from index 3, so 0 is granted first only if 3 is idle; here grant=0 then 2, confirming wrap.
4. Illegal slot: req=0010, slot=6. Required: at E2 ack=0010 and err=1, WE stays 0, WriteBus unchanged.
5. Gating and abort: EnableChange=0 with req=0001 -> no grant, busy=0. Raise EnableChange -> grant. Drop reset at E1 -> WE never asserts, all outputs 0, no ack. After reset release the request is re-served from rr_ptr=0.
6. Same-address chain: requester 0 writes slot 0 then slot 1 of row 0x7FF, with the RAM model updated on writes. Required: second read returns the first write, and the final row contains both elements.
